// File: rtl/arb8_ctrl_pkg.sv
// Shared constants and state encoding for the 8-way grant arbiter.
package arb8_ctrl_pkg;

  localparam int NUM_REQ = 8;
  localparam int ID_W    = 3;
  localparam int CNT_W   = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

endpackage

// File: rtl/arb_pick8.sv
// Combinational rotated priority pick: searches req downward from ptr with wrap.
module arb_pick8
  import arb8_ctrl_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [ID_W-1:0]    id,
  output logic               any
);

  // Walk from lowest to highest priority so the last match wins.
  always_comb begin
    id  = ptr;
    any = |req;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[ptr - ID_W'(i)]) id = ptr - ID_W'(i);
    end
  end

endmodule

// File: rtl/arb8_ctrl.sv
// 8-requester arbiter with hold limit; define ARB8_ROUND_ROBIN_EN for rotating
// priority, otherwise fixed priority with req[7] highest.
module arb8_ctrl
  import arb8_ctrl_pkg::*;
#(
  parameter int HOLD_MAX = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               done,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    gnt_id,
  output logic               gnt_valid,
  output logic               timeout
);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [ID_W-1:0]    gnt_id_q, gnt_id_d;
  logic               gnt_valid_q, gnt_valid_d;
  logic               timeout_q, timeout_d;
  logic [ID_W-1:0]    ptr;
  logic [ID_W-1:0]    pick_id;
  logic               pick_any;
  logic               expire;
  logic               release_now;

  arb_pick8 u_pick (
    .req (req),
    .ptr (ptr),
    .id  (pick_id),
    .any (pick_any)
  );

`ifdef ARB8_ROUND_ROBIN_EN
  logic [ID_W-1:0] ptr_q, ptr_d;

  // The just-granted requester drops to lowest priority on the next search.
  always_comb begin
    ptr_d = ptr_q;
    if (state_q == IDLE && pick_any) ptr_d = pick_id - ID_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '1;
    else     ptr_q <= ptr_d;
  end

  assign ptr = ptr_q;
`else
  assign ptr = '1;
`endif

  assign expire      = (cnt_q >= CNT_W'(HOLD_MAX - 1));
  assign release_now = done | ~req[gnt_id_q] | expire;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d = GRANT;
          cnt_d   = '0;
        end
      end
      GRANT: begin
        if (release_now)       state_d = IDLE;
        else if (cnt_q != '1)  cnt_d   = cnt_q + CNT_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs only move on entry to or exit from GRANT; gnt_id keeps its last value in IDLE.
  always_comb begin
    gnt_d       = gnt_q;
    gnt_id_d    = gnt_id_q;
    gnt_valid_d = gnt_valid_q;
    timeout_d   = 1'b0;
    if (state_q == IDLE) begin
      if (pick_any) begin
        gnt_d          = '0;
        gnt_d[pick_id] = 1'b1;
        gnt_id_d       = pick_id;
        gnt_valid_d    = 1'b1;
      end
    end else if (release_now) begin
      gnt_d       = '0;
      gnt_valid_d = 1'b0;
      timeout_d   = expire & ~done & req[gnt_id_q];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      gnt_q       <= '0;
      gnt_id_q    <= '0;
      gnt_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      gnt_q       <= gnt_d;
      gnt_id_q    <= gnt_id_d;
      gnt_valid_q <= gnt_valid_d;
      timeout_q   <= timeout_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_id    = gnt_id_q;
  assign gnt_valid = gnt_valid_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_arb8_ctrl.sv
// Directed-vector bench for arb8_ctrl with HOLD_MAX=4; expectations follow ARB8_ROUND_ROBIN_EN.
module tb_arb8_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req;
  logic       done;
  logic [7:0] gnt;
  logic [2:0] gnt_id;
  logic       gnt_valid;
  logic       timeout;

  int vecCount  = 0;
  int missCount = 0;

  arb8_ctrl #(.HOLD_MAX(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .done      (done),
    .gnt       (gnt),
    .gnt_id    (gnt_id),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs, then let the edge happen and settle past it.
  task automatic applyStimulus(input logic [7:0] r, input logic d, input logic rs);
    req  = r;
    done = d;
    rst  = rs;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vecCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  initial begin
    logic [2:0] expId;

    req = '0; done = 1'b0; rst = 1'b1;
    #1;
    applyStimulus(8'h00, 1'b0, 1'b1);
    applyStimulus(8'h00, 1'b0, 1'b1);
    checkOutput("rst_gnt",     32'(gnt),       32'h0);
    checkOutput("rst_gnt_id",  32'(gnt_id),    32'h0);
    checkOutput("rst_valid",   32'(gnt_valid), 32'h0);
    checkOutput("rst_timeout", 32'(timeout),   32'h0);

    // req=05 held, done on fourth grant cycle coincides with hold expiry
    applyStimulus(8'h05, 1'b0, 1'b0);
    checkOutput("a_gnt",    32'(gnt),       32'h04);
    checkOutput("a_id",     32'(gnt_id),    32'h2);
    checkOutput("a_valid",  32'(gnt_valid), 32'h1);
    applyStimulus(8'h05, 1'b0, 1'b0);
    applyStimulus(8'h05, 1'b0, 1'b0);
    checkOutput("a_hold",   32'(gnt),       32'h04);
    applyStimulus(8'h05, 1'b0, 1'b0);
    checkOutput("a_hold2",  32'(gnt),       32'h04);
    applyStimulus(8'h05, 1'b1, 1'b0);
    checkOutput("a_rel_gnt",   32'(gnt),       32'h0);
    checkOutput("a_rel_valid", 32'(gnt_valid), 32'h0);
    checkOutput("a_rel_to",    32'(timeout),   32'h0);
    applyStimulus(8'h05, 1'b0, 1'b0);
`ifdef ARB8_ROUND_ROBIN_EN
    checkOutput("a_regrant", 32'(gnt), 32'h01);
`else
    checkOutput("a_regrant", 32'(gnt), 32'h04);
`endif
    applyStimulus(8'h00, 1'b0, 1'b0);
    checkOutput("a_drop", 32'(gnt), 32'h0);
    applyStimulus(8'h00, 1'b0, 1'b0);

    // hold expiry with req still high forces a timeout
    applyStimulus(8'h00, 1'b0, 1'b1);
    applyStimulus(8'h10, 1'b0, 1'b0);
    checkOutput("b_gnt1", 32'(gnt), 32'h10);
    applyStimulus(8'h10, 1'b0, 1'b0);
    checkOutput("b_gnt2", 32'(gnt), 32'h10);
    applyStimulus(8'h10, 1'b0, 1'b0);
    checkOutput("b_gnt3", 32'(gnt), 32'h10);
    applyStimulus(8'h10, 1'b0, 1'b0);
    checkOutput("b_gnt4", 32'(gnt),     32'h10);
    checkOutput("b_to0",  32'(timeout), 32'h0);
    applyStimulus(8'h10, 1'b0, 1'b0);
    checkOutput("b_exp_gnt", 32'(gnt),     32'h0);
    checkOutput("b_exp_to",  32'(timeout), 32'h1);
    applyStimulus(8'h10, 1'b0, 1'b0);
    checkOutput("b_regrant", 32'(gnt),     32'h10);
    checkOutput("b_to_end",  32'(timeout), 32'h0);
    applyStimulus(8'h00, 1'b0, 1'b0);
    checkOutput("b_drop_to", 32'(timeout), 32'h0);

    // holder drops its request while a higher one arrives
    applyStimulus(8'h00, 1'b0, 1'b1);
    applyStimulus(8'h08, 1'b0, 1'b0);
    checkOutput("c_gnt", 32'(gnt), 32'h08);
    applyStimulus(8'h80, 1'b0, 1'b0);
    checkOutput("c_rel_gnt", 32'(gnt),     32'h0);
    checkOutput("c_rel_to",  32'(timeout), 32'h0);
    applyStimulus(8'h80, 1'b0, 1'b0);
    checkOutput("c_new_gnt", 32'(gnt),    32'h80);
    checkOutput("c_new_id",  32'(gnt_id), 32'h7);
    applyStimulus(8'h00, 1'b0, 1'b0);

    // reset mid-grant, then fresh arbitration from ptr=7
    applyStimulus(8'h00, 1'b0, 1'b1);
    applyStimulus(8'h20, 1'b0, 1'b0);
    checkOutput("d_gnt", 32'(gnt), 32'h20);
    applyStimulus(8'h20, 1'b0, 1'b1);
    checkOutput("d_rst_gnt",   32'(gnt),       32'h0);
    checkOutput("d_rst_valid", 32'(gnt_valid), 32'h0);
    applyStimulus(8'h21, 1'b0, 1'b0);
    checkOutput("d_id", 32'(gnt_id), 32'h5);
    applyStimulus(8'h00, 1'b0, 1'b0);
    applyStimulus(8'h00, 1'b0, 1'b0);

    // done in IDLE is ignored
    applyStimulus(8'h00, 1'b1, 1'b0);
    applyStimulus(8'h00, 1'b1, 1'b0);
    checkOutput("e_gnt",   32'(gnt),       32'h0);
    checkOutput("e_valid", 32'(gnt_valid), 32'h0);
    checkOutput("e_to",    32'(timeout),   32'h0);

    // all requesting, done pulsed each grant
    applyStimulus(8'h00, 1'b0, 1'b1);
    for (int k = 0; k < 9; k++) begin
`ifdef ARB8_ROUND_ROBIN_EN
      expId = 3'(7 - k);
`else
      expId = 3'd7;
`endif
      applyStimulus(8'hFF, 1'b0, 1'b0);
      checkOutput($sformatf("f_id%0d", k), 32'(gnt_id), 32'(expId));
      applyStimulus(8'hFF, 1'b1, 1'b0);
      checkOutput($sformatf("f_rel%0d", k), 32'(gnt), 32'h0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
